// File: rtl/mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_stage
// Description : RV64 MEM stage. It steers store lanes and extends loads. It
//               handles data-memory handshakes with a wait timeout and
//               registers the MEM/WB boundary.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_stage #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] adder_out,
    input  logic [63:0] alu_result,
    input  logic        zero,
    input  logic [63:0] write_data,
    input  logic [4:0]  rd,
    input  logic        branch,
    input  logic        memread,
    input  logic        memtoreg,
    input  logic        memwrite,
    input  logic        regwrite,
    input  logic [2:0]  funct3,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [63:0] dmem_addr,
    output logic [63:0] dmem_wdata,
    output logic [7:0]  dmem_wstrb,
    input  logic        dmem_ready,
    input  logic [63:0] dmem_rdata,
    output logic        pcsrc,
    output logic [63:0] branch_target,
    output logic        mem_stall,
    output logic        misalign_err,
    output logic        bus_err,
    output logic [63:0] wb_read_data,
    output logic [63:0] wb_alu_result,
    output logic [4:0]  wb_rd,
    output logic        wb_memtoreg,
    output logic        wb_regwrite
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;

    logic [2:0]  w_off;
    logic [1:0]  w_size;
    logic        w_memop;
    logic        w_misalign;
    logic        w_fault_mis;
    logic        w_timeout;
    logic        w_req;
    logic        w_stall;
    logic [7:0]  w_strb_base;
    logic [63:0] w_shifted;
    logic [63:0] w_load;

    assign w_off   = alu_result[2:0];
    assign w_size  = funct3[1:0];
    assign w_memop = memread | memwrite;

    always_comb begin
        w_misalign  = 1'b0;
        w_strb_base = 8'h01;
        case (w_size)
            2'd0: begin w_misalign = 1'b0;              w_strb_base = 8'h01; end
            2'd1: begin w_misalign = w_off[0];          w_strb_base = 8'h03; end
            2'd2: begin w_misalign = |w_off[1:0];       w_strb_base = 8'h0F; end
            default: begin w_misalign = |w_off;         w_strb_base = 8'hFF; end
        endcase
    end

    assign w_fault_mis = (r_state == S_IDLE) & w_memop & w_misalign;
    assign w_timeout   = (r_state == S_WAIT) & (r_cnt == CNT_W'(TIMEOUT_CYCLES)) & ~dmem_ready;

    // Gated by reset so the request and stall drop as soon as reset asserts.
    assign w_req   = reset & (((r_state == S_IDLE) & w_memop & ~w_misalign) |
                              ((r_state == S_WAIT) & ~w_timeout));
    assign w_stall = w_req & ~dmem_ready;

    assign dmem_req   = w_req;
    assign mem_stall  = w_stall;
    assign dmem_we    = w_req & memwrite;
    assign dmem_addr  = {alu_result[63:3], 3'b000};
    assign dmem_wdata = write_data << {w_off, 3'b000};
    assign dmem_wstrb = w_strb_base << w_off;

    assign pcsrc         = branch & zero;
    assign branch_target = adder_out;

    assign w_shifted = dmem_rdata >> {w_off, 3'b000};

    always_comb begin
        w_load = w_shifted;
        case (funct3)
            3'b000:  w_load = {{56{w_shifted[7]}},  w_shifted[7:0]};
            3'b001:  w_load = {{48{w_shifted[15]}}, w_shifted[15:0]};
            3'b010:  w_load = {{32{w_shifted[31]}}, w_shifted[31:0]};
            3'b011:  w_load = w_shifted;
            3'b100:  w_load = {56'd0, w_shifted[7:0]};
            3'b101:  w_load = {48'd0, w_shifted[15:0]};
            3'b110:  w_load = {32'd0, w_shifted[31:0]};
            default: w_load = w_shifted;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            misalign_err  <= 1'b0;
            bus_err       <= 1'b0;
            wb_read_data  <= '0;
            wb_alu_result <= '0;
            wb_rd         <= '0;
            wb_memtoreg   <= 1'b0;
            wb_regwrite   <= 1'b0;
        end else begin
            misalign_err <= w_fault_mis;
            bus_err      <= w_timeout;

            case (r_state)
                S_IDLE: begin
                    if (w_memop & ~w_misalign & ~dmem_ready) begin
                        r_state <= S_WAIT;
                        r_cnt   <= CNT_W'(1);
                    end
                end
                S_WAIT: begin
                    if (dmem_ready | w_timeout) begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                end
            endcase

            // A stalled cycle pushes a bubble so WB never retires a half-done access.
            if (w_stall) begin
                wb_rd       <= '0;
                wb_memtoreg <= 1'b0;
                wb_regwrite <= 1'b0;
            end else begin
                wb_alu_result <= alu_result;
                wb_rd         <= rd;
                wb_memtoreg   <= memtoreg;
                wb_regwrite   <= regwrite & ~w_fault_mis & ~w_timeout;
                wb_read_data  <= (memread & ~w_fault_mis & ~w_timeout) ? w_load : 64'd0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_stage
// Description : Directed scoreboard bench for mem_access_stage.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] adder_out, alu_result, write_data, dmem_rdata;
    logic        zero, branch, memread, memtoreg, memwrite, regwrite, dmem_ready;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic        dmem_req, dmem_we, pcsrc, mem_stall, misalign_err, bus_err;
    logic        wb_memtoreg, wb_regwrite;
    logic [63:0] dmem_addr, dmem_wdata, branch_target, wb_read_data, wb_alu_result;
    logic [7:0]  dmem_wstrb;
    logic [4:0]  wb_rd;

    mem_access_stage #(.TIMEOUT_CYCLES(16), .CNT_W(5)) dut (
        .clk(clk), .reset(reset), .adder_out(adder_out), .alu_result(alu_result),
        .zero(zero), .write_data(write_data), .rd(rd), .branch(branch),
        .memread(memread), .memtoreg(memtoreg), .memwrite(memwrite),
        .regwrite(regwrite), .funct3(funct3), .dmem_req(dmem_req),
        .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_wstrb(dmem_wstrb), .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
        .pcsrc(pcsrc), .branch_target(branch_target), .mem_stall(mem_stall),
        .misalign_err(misalign_err), .bus_err(bus_err), .wb_read_data(wb_read_data),
        .wb_alu_result(wb_alu_result), .wb_rd(wb_rd), .wb_memtoreg(wb_memtoreg),
        .wb_regwrite(wb_regwrite)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] rdata;
        logic [63:0] alu;
        logic [4:0]  rd;
        logic        rw;
        logic        m2r;
        logic        mis;
        logic        be;
    } wb_t;

    wb_t sb[$];
    int  total = 0;
    int  bad   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Byte-wise reference for load extraction and extension.
    function automatic logic [63:0] ld_model(input logic [63:0] d, input logic [2:0] f3,
                                             input logic [2:0] off);
        logic [7:0]  b[8];
        logic [63:0] r;
        int          n;
        for (int i = 0; i < 8; i++) b[i] = d[8*i +: 8];
        n = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : (f3[1:0] == 2'd2) ? 4 : 8;
        r = '0;
        for (int i = 0; i < n; i++) r[8*i +: 8] = b[int'(off) + i];
        if (!f3[2] && n < 8 && b[int'(off) + n - 1][7])
            for (int i = n; i < 8; i++) r[8*i +: 8] = 8'hFF;
        return r;
    endfunction

    task automatic set_instr(input logic mr, input logic mw, input logic rw, input logic m2r,
                             input logic [2:0] f3, input logic [63:0] a,
                             input logic [63:0] wd, input logic [4:0] r);
        memread = mr; memwrite = mw; regwrite = rw; memtoreg = m2r;
        funct3 = f3; alu_result = a; write_data = wd; rd = r;
    endtask

    task automatic push(input logic [63:0] rdv, input logic rw, input logic m2r,
                        input logic mis, input logic be);
        wb_t e;
        e.rdata = rdv; e.alu = alu_result; e.rd = rd; e.rw = rw;
        e.m2r = m2r; e.mis = mis; e.be = be;
        sb.push_back(e);
    endtask

    // Called just after a negedge with the instruction already driven.
    task automatic run_instr(input string tag, input int wait_cycles, input logic [63:0] rdv,
                             input int exp_stalls, input logic final_req);
        int   stalls = 0;
        logic done   = 1'b0;
        logic st;
        wb_t  e;
        for (int c = 0; c < 40 && !done; c++) begin
            dmem_ready = (c == wait_cycles);
            dmem_rdata = (c == wait_cycles) ? rdv : 64'hA5A5_5A5A_C3C3_3C3C;
            #2;
            st = mem_stall;
            if (!st) chk({tag, "_req"}, dmem_req, final_req);
            @(posedge clk); #1;
            if (st) begin
                stalls++;
                chk({tag, "_bubble"}, wb_regwrite, 1'b0);
                @(negedge clk);
            end else begin
                done = 1'b1;
            end
        end
        chk({tag, "_done"}, done, 1'b1);
        chk({tag, "_stalls"}, stalls, exp_stalls);
        chk({tag, "_sb"}, sb.size(), 1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, "_rdata"}, wb_read_data, e.rdata);
            chk({tag, "_alu"}, wb_alu_result, e.alu);
            chk({tag, "_rd"}, wb_rd, e.rd);
            chk({tag, "_rw"}, wb_regwrite, e.rw);
            chk({tag, "_m2r"}, wb_memtoreg, e.m2r);
            chk({tag, "_mis"}, misalign_err, e.mis);
            chk({tag, "_be"}, bus_err, e.be);
        end
        @(negedge clk);
        memread = 1'b0; memwrite = 1'b0; dmem_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] rdv;
        reset = 1'b0; branch = 1'b0; zero = 1'b0; adder_out = '0; dmem_ready = 1'b0;
        dmem_rdata = '0;
        set_instr(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 64'd0, 64'd0, 5'd0);

        // Reset with random inputs.
        repeat (3) begin
            @(negedge clk);
            set_instr($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 1'b1, 1'b1,
                      3'($urandom), {$urandom, $urandom}, {$urandom, $urandom}, 5'($urandom));
            dmem_ready = $urandom_range(0, 1) == 1;
            dmem_rdata = {$urandom, $urandom};
            #1;
            chk("rst_req", dmem_req, 1'b0);
            chk("rst_stall", mem_stall, 1'b0);
            chk("rst_mis", misalign_err, 1'b0);
            chk("rst_be", bus_err, 1'b0);
            chk("rst_wbrd", wb_read_data, 64'd0);
            chk("rst_wbalu", wb_alu_result, 64'd0);
            chk("rst_wbrw", {wb_rd, wb_regwrite, wb_memtoreg}, 7'd0);
        end
        @(negedge clk);
        reset = 1'b1; dmem_ready = 1'b0;
        set_instr(1'b0, 1'b0, 1'b0, 1'b0, 3'b011, 64'h1000, 64'd0, 5'd0);
        #1;
        chk("post_rst_req", dmem_req, 1'b0);
        chk("post_rst_stall", mem_stall, 1'b0);
        @(negedge clk);

        // Zero-wait ld.
        rdv = 64'h1122_3344_5566_7788;
        set_instr(1'b1, 1'b0, 1'b1, 1'b1, 3'b011, 64'h1000, 64'd0, 5'd5);
        push(64'h1122_3344_5566_7788, 1'b1, 1'b1, 1'b0, 1'b0);
        run_instr("ld0", 0, rdv, 0, 1'b1);

        // Waited lb, then lbu, both on byte 3.
        rdv = 64'h0000_0000_8000_0000;
        set_instr(1'b1, 1'b0, 1'b1, 1'b1, 3'b000, 64'h1003, 64'd0, 5'd6);
        push(64'hFFFF_FFFF_FFFF_FF80, 1'b1, 1'b1, 1'b0, 1'b0);
        run_instr("lb", 2, rdv, 2, 1'b1);
        set_instr(1'b1, 1'b0, 1'b1, 1'b1, 3'b100, 64'h1003, 64'd0, 5'd7);
        push(64'h80, 1'b1, 1'b1, 1'b0, 1'b0);
        run_instr("lbu", 1, rdv, 1, 1'b1);

        // Assorted aligned loads checked against the byte model.
        rdv = 64'h8001_F234_9ABC_7E01;
        set_instr(1'b1, 1'b0, 1'b1, 1'b1, 3'b001, 64'h1006, 64'd0, 5'd8);
        push(ld_model(rdv, 3'b001, 3'd6), 1'b1, 1'b1, 1'b0, 1'b0);
        run_instr("lh", 0, rdv, 0, 1'b1);
        set_instr(1'b1, 1'b0, 1'b1, 1'b1, 3'b101, 64'h1006, 64'd0, 5'd9);
        push(ld_model(rdv, 3'b101, 3'd6), 1'b1, 1'b1, 1'b0, 1'b0);
        run_instr("lhu", 1, rdv, 1, 1'b1);
        set_instr(1'b1, 1'b0, 1'b1, 1'b1, 3'b010, 64'h1000, 64'd0, 5'd10);
        push(ld_model(rdv, 3'b010, 3'd0), 1'b1, 1'b1, 1'b0, 1'b0);
        run_instr("lw", 0, rdv, 0, 1'b1);
        set_instr(1'b1, 1'b0, 1'b1, 1'b1, 3'b110, 64'h1004, 64'd0, 5'd11);
        push(ld_model(rdv, 3'b110, 3'd4), 1'b1, 1'b1, 1'b0, 1'b0);
        run_instr("lwu", 0, rdv, 0, 1'b1);

        // sw at 0x2004.
        set_instr(1'b0, 1'b1, 1'b0, 1'b0, 3'b010, 64'h2004, 64'hDEAD_BEEF, 5'd0);
        dmem_ready = 1'b1;
        #1;
        chk("sw_we", dmem_we, 1'b1);
        chk("sw_strb", dmem_wstrb, 8'hF0);
        chk("sw_wdata", dmem_wdata, 64'hDEAD_BEEF_0000_0000);
        chk("sw_addr", dmem_addr, 64'h2000);
        push(64'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        run_instr("sw", 0, 64'd0, 0, 1'b1);

        // sb at byte 5 and sd.
        set_instr(1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 64'h2005, 64'h0000_0000_0000_00AB, 5'd0);
        #1;
        chk("sb_strb", dmem_wstrb, 8'h20);
        chk("sb_wdata", dmem_wdata, 64'h0000_AB00_0000_0000);
        push(64'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        run_instr("sb", 1, 64'd0, 1, 1'b1);
        set_instr(1'b0, 1'b1, 1'b0, 1'b0, 3'b011, 64'h2008, 64'h0123_4567_89AB_CDEF, 5'd0);
        #1;
        chk("sd_strb", dmem_wstrb, 8'hFF);
        chk("sd_wdata", dmem_wdata, 64'h0123_4567_89AB_CDEF);
        push(64'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        run_instr("sd", 0, 64'd0, 0, 1'b1);

        // Misaligned lw, then a plain ALU op that must see the pulse gone.
        set_instr(1'b1, 1'b0, 1'b1, 1'b1, 3'b010, 64'h1002, 64'd0, 5'd12);
        push(64'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        run_instr("mis_lw", 0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 1'b0);
        set_instr(1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 64'h55, 64'd0, 5'd7);
        push(64'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        run_instr("alu1", 0, 64'd0, 0, 1'b0);

        // Read that never completes: 16 stalled cycles, then abort.
        set_instr(1'b1, 1'b0, 1'b1, 1'b1, 3'b011, 64'h3000, 64'd0, 5'd13);
        push(64'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        run_instr("tmo", -1, 64'd0, 16, 1'b0);
        set_instr(1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 64'h66, 64'd0, 5'd14);
        push(64'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        run_instr("alu2", 0, 64'd0, 0, 1'b0);

        // Branch resolution.
        branch = 1'b1; zero = 1'b1; adder_out = 64'h400;
        #1;
        chk("br_pcsrc1", pcsrc, 1'b1);
        chk("br_target", branch_target, 64'h400);
        zero = 1'b0;
        #1;
        chk("br_pcsrc0", pcsrc, 1'b0);
        branch = 1'b0;

        // Reset asserted mid-WAIT.
        @(negedge clk);
        set_instr(1'b1, 1'b0, 1'b1, 1'b1, 3'b011, 64'h1000, 64'd0, 5'd3);
        dmem_ready = 1'b0;
        @(negedge clk); #1;
        chk("mw_stall", mem_stall, 1'b1);
        reset = 1'b0;
        #1;
        chk("mw_req", dmem_req, 1'b0);
        chk("mw_stall0", mem_stall, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        set_instr(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 64'd0, 64'd0, 5'd0);
        #1;
        chk("mw_idle_req", dmem_req, 1'b0);
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
